// File: rtl/wieg_regelaar.sv
// -----------------------------------------------------------------------------
// wieg_regelaar - cradle rocking controller driven by a heart-rate stress
// detector.
//
// The detector announces a stable measurement with gelijk_puls and tells
// whether stress improved (gedaald) or worsened (error). This block keeps an
// intensity level ("stand"), swings the cradle motor left/right with a
// half-period that shortens as the stand rises, pauses after every stand
// change so the baby can settle, and raises an alarm when stress keeps rising
// at maximum intensity.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   tick         in   slow time-base enable, one clk wide
//   start        in   begin rocking (level, only honoured while off)
//   stop         in   stop rocking from any state (wins over start)
//   gelijk_puls  in   stable-measurement pulse from detector (asynchronous)
//   gedaald      in   stress improved flag (asynchronous)
//   error        in   stress worsened flag (asynchronous)
//   stand        out  current intensity level
//   motor_links  out  drive motor toward the left
//   motor_rechts out  drive motor toward the right
//   klaar        out  one-clk pulse when the baby is calm and rocking ends
//   alarm        out  high while in the alarm state
// -----------------------------------------------------------------------------
module wieg_regelaar #(
  parameter int MAX_STAND    = 7,
  parameter int START_STAND  = 3,
  parameter int HALF_BASE    = 20,
  parameter int SETTLE_TICKS = 16,
  parameter int MAX_FOUT     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       gelijk_puls,
  input  logic       gedaald,
  input  logic       error,
  output logic [2:0] stand,
  output logic       motor_links,
  output logic       motor_rechts,
  output logic       klaar,
  output logic       alarm
);

  localparam int HW = $clog2(HALF_BASE + 1);
  localparam int SW = $clog2(SETTLE_TICKS + 1);
  localparam int FW = $clog2(MAX_FOUT + 1);

  localparam logic [2:0]    STAND_MAX   = 3'(MAX_STAND);
  localparam logic [2:0]    STAND_INIT  = 3'(START_STAND);
  localparam logic [HW-1:0] HALF_B      = HW'(HALF_BASE);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_TICKS - 1);
  localparam logic [FW-1:0] FOUT_MAX    = FW'(MAX_FOUT);
  localparam logic [FW-1:0] FOUT_LAST   = FW'(MAX_FOUT - 1);

  typedef enum logic [1:0] {
    ST_UIT    = 2'd0,
    ST_WIEGEN = 2'd1,
    ST_PAUZE  = 2'd2,
    ST_ALARM  = 2'd3
  } state_t;

  // Synchroniser flops (meta + stable stage) and edge-detect history.
  logic r_gp_m, r_gp_s, r_gp_d;
  logic r_ge_m, r_ge_s;
  logic r_er_m, r_er_s;

  state_t        r_state;
  logic [2:0]    r_stand;
  logic [FW-1:0] r_fout;
  logic [SW-1:0] r_settle;
  logic [HW-1:0] r_half;
  logic [HW-1:0] r_phase;
  logic          r_dir;    // 0 = left half, 1 = right half
  logic          r_dead;   // one-clk gap after a direction change
  logic          r_ml, r_mr, r_klaar, r_alarm;

  logic          w_event, w_worse, w_better;
  logic          w_swing, w_phase_end, w_settle_end;
  logic [HW-1:0] w_half_next;

  assign w_event      = r_gp_s & ~r_gp_d;
  assign w_worse      = r_er_s;              // error wins over gedaald
  assign w_better     = ~r_er_s & r_ge_s;
  assign w_swing      = (r_state == ST_WIEGEN) | (r_state == ST_PAUZE);
  assign w_phase_end  = tick & (r_phase == (r_half - HW'(1'b1)));
  assign w_settle_end = (r_settle == SETTLE_LAST);
  assign w_half_next  = HALF_B - HW'({r_stand, 1'b0});

  // Two-flop synchronisers for the detector inputs plus edge history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gp_m <= 1'b0;
      r_gp_s <= 1'b0;
      r_gp_d <= 1'b0;
      r_ge_m <= 1'b0;
      r_ge_s <= 1'b0;
      r_er_m <= 1'b0;
      r_er_s <= 1'b0;
    end else begin
      r_gp_m <= gelijk_puls;
      r_gp_s <= r_gp_m;
      r_gp_d <= r_gp_s;
      r_ge_m <= gedaald;
      r_ge_s <= r_ge_m;
      r_er_m <= error;
      r_er_s <= r_er_m;
    end
  end

  // Control FSM, swing generator and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_UIT;
      r_stand  <= 3'd0;
      r_fout   <= {FW{1'b0}};
      r_settle <= {SW{1'b0}};
      r_half   <= {HW{1'b0}};
      r_phase  <= {HW{1'b0}};
      r_dir    <= 1'b0;
      r_dead   <= 1'b0;
      r_ml     <= 1'b0;
      r_mr     <= 1'b0;
      r_klaar  <= 1'b0;
      r_alarm  <= 1'b0;
    end else begin
      r_klaar <= 1'b0;

      // Swing: the half-period length is only reloaded at a boundary, so a
      // stand change never truncates the half that is running.
      if (w_swing) begin
        if (w_phase_end) begin
          r_phase <= {HW{1'b0}};
          r_dir   <= ~r_dir;
          r_dead  <= 1'b1;
          r_ml    <= 1'b0;
          r_mr    <= 1'b0;
          r_half  <= w_half_next;
        end else begin
          if (tick) begin
            r_phase <= r_phase + HW'(1'b1);
          end
          if (r_dead) begin
            r_dead <= 1'b0;
            r_ml   <= ~r_dir;
            r_mr   <= r_dir;
          end
        end
      end

      // State transitions; motor writes here override the swing above.
      if (stop) begin
        r_state  <= ST_UIT;
        r_stand  <= 3'd0;
        r_fout   <= {FW{1'b0}};
        r_settle <= {SW{1'b0}};
        r_phase  <= {HW{1'b0}};
        r_dir    <= 1'b0;
        r_dead   <= 1'b0;
        r_ml     <= 1'b0;
        r_mr     <= 1'b0;
        r_alarm  <= 1'b0;
      end else begin
        case (r_state)
          ST_UIT: begin
            if (start) begin
              r_state <= ST_WIEGEN;
              r_stand <= STAND_INIT;
              r_fout  <= {FW{1'b0}};
              r_phase <= {HW{1'b0}};
              r_dir   <= 1'b0;
              r_dead  <= 1'b0;
              r_half  <= HALF_B - HW'({STAND_INIT, 1'b0});
              r_ml    <= 1'b1;
              r_mr    <= 1'b0;
            end
          end
          ST_WIEGEN: begin
            if (w_event) begin
              if (w_worse) begin
                if (r_stand < STAND_MAX) begin
                  r_stand  <= r_stand + 3'd1;
                  r_fout   <= {FW{1'b0}};
                  r_settle <= {SW{1'b0}};
                  r_state  <= ST_PAUZE;
                end else if (r_fout >= FOUT_LAST) begin
                  // fout saturates here; only stop or reset clear it
                  r_fout  <= FOUT_MAX;
                  r_alarm <= 1'b1;
                  r_ml    <= 1'b0;
                  r_mr    <= 1'b0;
                  r_state <= ST_ALARM;
                end else begin
                  r_fout   <= r_fout + FW'(1'b1);
                  r_settle <= {SW{1'b0}};
                  r_state  <= ST_PAUZE;
                end
              end else if (w_better) begin
                if (r_stand != 3'd0) begin
                  r_stand  <= r_stand - 3'd1;
                  r_fout   <= {FW{1'b0}};
                  r_settle <= {SW{1'b0}};
                  r_state  <= ST_PAUZE;
                end else begin
                  r_klaar <= 1'b1;
                  r_ml    <= 1'b0;
                  r_mr    <= 1'b0;
                  r_state <= ST_UIT;
                end
              end else begin
                r_fout <= {FW{1'b0}};
              end
            end
          end
          ST_PAUZE: begin
            // events are simply not looked at here, so they are dropped
            if (tick) begin
              if (w_settle_end) begin
                r_settle <= {SW{1'b0}};
                r_state  <= ST_WIEGEN;
              end else begin
                r_settle <= r_settle + SW'(1'b1);
              end
            end
          end
          ST_ALARM: begin
            r_alarm <= 1'b1;
            r_ml    <= 1'b0;
            r_mr    <= 1'b0;
          end
          default: begin
            r_state <= ST_UIT;
            r_ml    <= 1'b0;
            r_mr    <= 1'b0;
            r_alarm <= 1'b0;
          end
        endcase
      end
    end
  end

  assign stand        = r_stand;
  assign motor_links  = r_ml;
  assign motor_rechts = r_mr;
  assign klaar        = r_klaar;
  assign alarm        = r_alarm;

endmodule

// File: tb/tb_wieg_regelaar.sv
module tb_wieg_regelaar;

  localparam int MAX_STAND    = 7;
  localparam int START_STAND  = 3;
  localparam int HALF_BASE    = 20;
  localparam int SETTLE_TICKS = 16;
  localparam int MAX_FOUT     = 3;

  logic       clk = 1'b0;
  logic       reset, tick, start, stop, gelijk_puls, gedaald, error;
  logic [2:0] stand;
  logic       motor_links, motor_rechts, klaar, alarm;

  int errs = 0;
  int checks = 0;
  int klaar_total = 0;
  bit tick_rand = 1'b0;
  int tick_div = 0;

  wieg_regelaar dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
    .gelijk_puls(gelijk_puls), .gedaald(gedaald), .error(error),
    .stand(stand), .motor_links(motor_links), .motor_rechts(motor_rechts),
    .klaar(klaar), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_OFF, M_ROCK, M_PAUSE, M_ALARM} mode_t;
  mode_t m_mode;
  int m_stand, m_fout, m_settle;
  int m_left_half;   // 1 while swinging left, 0 while swinging right
  int m_ticks_in_half, m_half_len;
  bit m_gap, m_klaar;
  bit h_gp[3], h_ge[3], h_er[3];   // [0] newest clk sample

  task automatic model_reset();
    m_mode = M_OFF; m_stand = 0; m_fout = 0; m_settle = 0;
    m_left_half = 1; m_ticks_in_half = 0; m_half_len = 0;
    m_gap = 0; m_klaar = 0;
    for (int i = 0; i < 3; i++) begin h_gp[i] = 0; h_ge[i] = 0; h_er[i] = 0; end
  endtask

  task automatic model_step();
    // an event is seen two clks after the pulse is first sampled high
    bit ev, f_ge, f_er;
    ev   = h_gp[1] && !h_gp[2];
    f_ge = h_ge[1];
    f_er = h_er[1];
    h_gp[2] = h_gp[1]; h_gp[1] = h_gp[0]; h_gp[0] = gelijk_puls;
    h_ge[2] = h_ge[1]; h_ge[1] = h_ge[0]; h_ge[0] = gedaald;
    h_er[2] = h_er[1]; h_er[1] = h_er[0]; h_er[0] = error;
    m_klaar = 0;
    if (stop) begin
      m_mode = M_OFF; m_stand = 0; m_fout = 0;
    end else if (m_mode == M_OFF) begin
      if (start) begin
        m_mode = M_ROCK; m_stand = START_STAND; m_fout = 0;
        m_left_half = 1; m_ticks_in_half = 0; m_gap = 0;
        m_half_len = HALF_BASE - 2 * START_STAND;
      end
    end else if (m_mode == M_ROCK || m_mode == M_PAUSE) begin
      m_gap = 0;
      if (tick) begin
        m_ticks_in_half++;
        if (m_ticks_in_half == m_half_len) begin
          m_ticks_in_half = 0;
          m_left_half = 1 - m_left_half;
          m_gap = 1;
          m_half_len = HALF_BASE - 2 * m_stand;
        end
      end
      if (m_mode == M_ROCK) begin
        if (ev) begin
          if (f_er) begin
            if (m_stand < MAX_STAND) begin
              m_stand++; m_fout = 0; m_mode = M_PAUSE; m_settle = 0;
            end else begin
              if (m_fout < MAX_FOUT) m_fout++;
              if (m_fout == MAX_FOUT) m_mode = M_ALARM;
              else begin m_mode = M_PAUSE; m_settle = 0; end
            end
          end else if (f_ge) begin
            if (m_stand > 0) begin
              m_stand--; m_fout = 0; m_mode = M_PAUSE; m_settle = 0;
            end else begin
              m_klaar = 1; m_mode = M_OFF;
            end
          end else begin
            m_fout = 0;
          end
        end
      end else if (tick) begin
        m_settle++;
        if (m_settle == SETTLE_TICKS) begin m_settle = 0; m_mode = M_ROCK; end
      end
    end
  endtask

  function automatic int model_vec();
    bit run, ml, mr, al;
    run = (m_mode == M_ROCK) || (m_mode == M_PAUSE);
    ml  = run && !m_gap && (m_left_half == 1);
    mr  = run && !m_gap && (m_left_half == 0);
    al  = (m_mode == M_ALARM);
    return m_stand * 16 + int'(ml) * 8 + int'(mr) * 4 + int'(m_klaar) * 2 + int'(al);
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // per-cycle compare of DUT against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("cycle", {27'd0, stand, motor_links, motor_rechts, klaar, alarm}, model_vec());
      chk("excl", {31'd0, motor_links & motor_rechts}, 32'd0);
      if (klaar) klaar_total++;
    end
  end

  // tick generator: every 4th clk in directed part, random later
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (tick_rand) tick = ($urandom_range(0, 3) == 0);
      else begin
        tick_div++;
        tick = (tick_div % 4 == 0);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ticks(input int n);
    int c = 0;
    int guard = 0;
    while (c < n && guard < 2000) begin
      @(posedge clk);
      if (tick) c++;
      #2;
      guard++;
    end
    chk("wait_ticks_bound", {31'd0, guard >= 2000}, 32'd0);
  endtask

  task automatic send_ev(input bit ge, input bit er);
    gedaald = ge;
    error   = er;
    repeat (3) step();
    gelijk_puls = 1'b1;
    repeat (3) step();
    gelijk_puls = 1'b0;
    step();
    gedaald = 1'b0;
    error   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n, k0, r, kind;
    bit found;
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    gelijk_puls = 1'b0; gedaald = 1'b0; error = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {27'd0, stand, motor_links, motor_rechts, klaar, alarm}, 32'd0);

    // start: stand 3, swing left, 14 ticks per half then one dead clk
    step();
    pulse_start();
    @(negedge clk);
    chk("start_stand", stand, 3);
    chk("start_left", motor_links, 1);
    n = 0; found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk);
      if (tick) n++;
      @(negedge clk);
      if (!motor_links) found = 1;
    end
    chk("left_fall_seen", found, 1);
    chk("half_ticks", n, 14);
    chk("dead_clk", {motor_links, motor_rechts}, 0);
    @(negedge clk);
    chk("right_rise", motor_rechts, 1);

    // WORSE: stand moves on the 3rd edge after gelijk_puls is first sampled
    step();
    error = 1'b1;
    repeat (3) step();
    gelijk_puls = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("latency_before", stand, 3);
    step();
    @(negedge clk);
    chk("latency_at", stand, 4);
    step();
    gelijk_puls = 1'b0;
    step();
    error = 1'b0;
    wait_ticks(5);
    send_ev(0, 1);
    chk("pause_discard", stand, 4);
    wait_ticks(16);
    send_ev(0, 1);
    chk("after_pause", stand, 5);

    // drive to max and trigger the alarm
    wait_ticks(18); send_ev(0, 1);
    wait_ticks(18); send_ev(0, 1);
    chk("at_max", stand, 7);
    for (int i = 0; i < 3; i++) begin
      wait_ticks(18);
      send_ev(0, 1);
      chk("alarm_progress", alarm, (i == 2) ? 1 : 0);
    end
    repeat (3) step();
    @(negedge clk);
    chk("alarm_motors", {motor_links, motor_rechts}, 0);
    chk("alarm_stand", stand, 7);
    pulse_stop();
    @(negedge clk);
    chk("stop_alarm", alarm, 0);
    chk("stop_stand", stand, 0);

    // W, W, EQUAL, W at max: EQUAL clears the worse count
    step();
    pulse_start();
    for (int i = 0; i < 4; i++) begin wait_ticks(18); send_ev(0, 1); end
    chk("pattern_max", stand, 7);
    wait_ticks(18); send_ev(0, 1);
    wait_ticks(18); send_ev(0, 1);
    wait_ticks(18); send_ev(0, 0);
    send_ev(0, 1);
    chk("equal_clears", alarm, 0);
    wait_ticks(18); send_ev(0, 1);
    chk("equal_clears2", alarm, 0);
    chk("pattern_stand", stand, 7);

    // BETTER down to 0 then klaar
    pulse_stop();
    pulse_start();
    for (int i = 0; i < 3; i++) begin wait_ticks(18); send_ev(1, 0); end
    chk("down_to_zero", stand, 0);
    wait_ticks(18);
    k0 = klaar_total;
    send_ev(1, 0);
    repeat (4) step();
    chk("klaar_once", klaar_total - k0, 1);
    chk("klaar_motors", {motor_links, motor_rechts}, 0);
    send_ev(0, 1);
    chk("off_ignores", stand, 0);

    // reset while swinging right in PAUZE
    pulse_start();
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (motor_rechts) found = 1;
    end
    chk("right_seen", found, 1);
    step();
    send_ev(0, 1);
    @(negedge clk);
    chk("pre_reset_right", motor_rechts, 1);
    chk("pre_reset_stand", stand, 4);
    step();
    reset = 1'b1;
    #1;
    chk("async_reset", {27'd0, stand, motor_links, motor_rechts, klaar, alarm}, 32'd0);
    start = 1'b1;
    send_ev(1, 1);
    @(negedge clk);
    chk("held_in_reset", {27'd0, stand, motor_links, motor_rechts, klaar, alarm}, 32'd0);
    step();
    start = 1'b0;
    reset = 1'b0;
    repeat (2) step();
    chk("after_release", stand, 0);
    pulse_start();
    send_ev(1, 1);
    chk("both_is_worse", stand, 4);

    // randomized phase
    tick_rand = 1'b1;
    for (int it = 0; it < 70; it++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        reset = 1'b1; repeat (3) step(); reset = 1'b0;
      end else if (r < 10) pulse_stop();
      else if (r < 22) pulse_start();
      else begin
        kind = $urandom_range(0, 9);
        if (kind < 5) send_ev(0, 1);
        else if (kind == 5) send_ev(1, 1);
        else if (kind < 8) send_ev(1, 0);
        else send_ev(0, 0);
      end
      repeat ($urandom_range(0, 60)) step();
    end

    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
